// File: rtl/cache_tag_mmu_if.sv
// cache_tag_mmu_if: CPU lookup, fill handshake and status signals of the page-tag cache controller.
interface cache_tag_mmu_if #(
    parameter int ADDR_W  = 24,
    parameter int PAGE_W  = 10,
    parameter int ENTRIES = 4
);
    localparam int TAG_W  = ADDR_W - PAGE_W;
    localparam int SLOT_W = $clog2(ENTRIES);
    logic [ADDR_W-1:0]        a;
    logic                     addrValid;
    logic                     flushAll;
    logic                     phi2;
    logic                     hit;
    logic [SLOT_W+PAGE_W-1:0] extAddr;
    logic                     fillReq;
    logic [TAG_W-1:0]         fillTag;
    logic [SLOT_W-1:0]        fillSlot;
    logic                     fillAck;
    logic [15:0]              missCount;
    modport slave (
        input  a, addrValid, flushAll, fillAck,
        output phi2, hit, extAddr, fillReq, fillTag, fillSlot, missCount
    );
    modport master (
        output a, addrValid, flushAll, fillAck,
        input  phi2, hit, extAddr, fillReq, fillTag, fillSlot, missCount
    );
endinterface

// File: rtl/cache_tag_mmu.sv
// cache_tag_mmu: phi2 generator with per-cycle page-tag lookup; a miss stalls phi2 low while a round-robin slot is filled.
module cache_tag_mmu #(
    parameter int ADDR_W     = 24,
    parameter int PAGE_W     = 10,
    parameter int ENTRIES    = 4,
    parameter int PHI_PERIOD = 10,
    parameter int PHI_HIGH   = 5
) (
    input logic fpgaClk,
    input logic fpgaRstN,
    cache_tag_mmu_if.slave bus
);
    localparam int TAG_W  = ADDR_W - PAGE_W;
    localparam int SLOT_W = $clog2(ENTRIES);
    localparam int CNT_W  = $clog2(PHI_PERIOD);
    typedef enum logic {RUN, FILL} state_t;
    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [TAG_W-1:0]         tagReg [ENTRIES];
    logic [ENTRIES-1:0]       valid;
    logic [SLOT_W-1:0]        victim;
    logic                     hitR;
    logic [SLOT_W+PAGE_W-1:0] extAddrR;
    logic                     fillReqR;
    logic [TAG_W-1:0]         fillTagR;
    logic [SLOT_W-1:0]        fillSlotR;
    logic [15:0]              missCnt;
    logic [TAG_W-1:0]         tag;
    logic                     matchAny;
    logic [SLOT_W-1:0]        matchIdx;
    logic                     lookup;
    assign tag    = bus.a[ADDR_W-1:PAGE_W];
    assign lookup = (state == RUN) && (cnt == CNT_W'(PHI_HIGH - 1));
    // Scan downwards so the lowest matching slot is the one left standing.
    always_comb begin
        matchAny = 1'b0;
        matchIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tagReg[i] == tag) begin
                matchAny = 1'b1;
                matchIdx = SLOT_W'(i);
            end
        end
    end
    always_ff @(posedge fpgaClk) begin
        if (!fpgaRstN) begin
            state     <= RUN;
            cnt       <= '0;
            valid     <= '0;
            victim    <= '0;
            hitR      <= 1'b0;
            extAddrR  <= '0;
            fillReqR  <= 1'b0;
            fillTagR  <= '0;
            fillSlotR <= '0;
            missCnt   <= '0;
            for (int i = 0; i < ENTRIES; i++) tagReg[i] <= '0;
        end else begin
            if (state == FILL) begin
                if (bus.fillAck) begin
                    tagReg[fillSlotR] <= fillTagR;
                    valid[fillSlotR]  <= 1'b1;
                    victim            <= victim + 1'b1;
                    fillReqR          <= 1'b0;
                    state             <= RUN;
                end
            end else if (lookup && bus.addrValid && !matchAny) begin
                state     <= FILL;
                hitR      <= 1'b0;
                fillReqR  <= 1'b1;
                fillTagR  <= tag;
                fillSlotR <= victim;
                missCnt   <= missCnt + {15'd0, ~&missCnt};
            end else begin
                cnt <= (cnt == CNT_W'(PHI_PERIOD - 1)) ? '0 : cnt + 1'b1;
                if (lookup) hitR <= bus.addrValid;
                if (lookup && bus.addrValid) extAddrR <= {matchIdx, bus.a[PAGE_W-1:0]};
            end
            // Flush overrides a coincident fill install.
            if (bus.flushAll) begin
                valid  <= '0;
                victim <= '0;
            end
        end
    end
    assign bus.phi2      = (cnt >= CNT_W'(PHI_HIGH));
    assign bus.hit       = hitR;
    assign bus.extAddr   = extAddrR;
    assign bus.fillReq   = fillReqR;
    assign bus.fillTag   = fillTagR;
    assign bus.fillSlot  = fillSlotR;
    assign bus.missCount = missCnt;
endmodule

// File: tb/tb_cache_tag_mmu.sv
// tb_cache_tag_mmu: directed accesses checked every cycle against a phase/tag-table model plus literal expectations.
module tb_cache_tag_mmu;
    localparam int ADDR_W = 24, PAGE_W = 10, ENTRIES = 4, PHI_PERIOD = 10, PHI_HIGH = 5;
    logic fpgaClk = 1'b0;
    logic fpgaRstN = 1'b0;
    always #5 fpgaClk = ~fpgaClk;
    cache_tag_mmu_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .ENTRIES(ENTRIES)) bus();
    cache_tag_mmu #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .ENTRIES(ENTRIES),
                    .PHI_PERIOD(PHI_PERIOD), .PHI_HIGH(PHI_HIGH))
        dut (.fpgaClk(fpgaClk), .fpgaRstN(fpgaRstN), .bus(bus));
    int nChecks = 0;
    int nFail = 0;
    bit checkOn = 1'b0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a phase number, a tag table where -1 means empty, and a stall flag.
    int mTag [ENTRIES];
    int mPhase, mVictim, mMiss, mExt, mFTag, mFSlot;
    bit mFill, mHit, mReq;
    function automatic int lookupSlot(input int t);
        for (int i = 0; i < ENTRIES; i++) if (mTag[i] == t) return i;
        return -1;
    endfunction
    function automatic int tagOf(input logic [ADDR_W-1:0] addr);
        return int'(addr) / (1 << PAGE_W);
    endfunction
    always @(posedge fpgaClk) begin
        if (!fpgaRstN) begin
            mPhase <= 0; mFill <= 0; mVictim <= 0; mMiss <= 0; mHit <= 0;
            mExt <= 0; mReq <= 0; mFTag <= 0; mFSlot <= 0;
            for (int i = 0; i < ENTRIES; i++) mTag[i] <= -1;
        end else begin
            if (mFill) begin
                if (bus.fillAck) begin
                    mTag[mFSlot] <= mFTag;
                    mVictim <= (mVictim + 1) % ENTRIES;
                    mReq <= 0;
                    mFill <= 0;
                end
            end else if (mPhase == PHI_HIGH - 1 && bus.addrValid && lookupSlot(tagOf(bus.a)) < 0) begin
                mFill <= 1; mReq <= 1; mHit <= 0;
                mFTag <= tagOf(bus.a);
                mFSlot <= mVictim;
                mMiss <= (mMiss < 65535) ? mMiss + 1 : mMiss;
            end else begin
                if (mPhase == PHI_HIGH - 1) begin
                    mHit <= bus.addrValid;
                    if (bus.addrValid)
                        mExt <= lookupSlot(tagOf(bus.a)) * (1 << PAGE_W) + int'(bus.a) % (1 << PAGE_W);
                end
                mPhase <= (mPhase + 1) % PHI_PERIOD;
            end
            if (bus.flushAll) begin
                for (int i = 0; i < ENTRIES; i++) mTag[i] <= -1;
                mVictim <= 0;
            end
        end
    end
    always @(negedge fpgaClk) begin
        if (checkOn) begin
            check("phi2", 32'(bus.phi2), 32'(mPhase >= PHI_HIGH));
            check("hit", 32'(bus.hit), 32'(mHit));
            check("extAddr", 32'(bus.extAddr), mExt);
            check("fillReq", 32'(bus.fillReq), 32'(mReq));
            check("missCount", 32'(bus.missCount), mMiss);
            if (mReq) begin
                check("fillTag", 32'(bus.fillTag), mFTag);
                check("fillSlot", 32'(bus.fillSlot), mFSlot);
            end
        end
    end
    task automatic waitPhiHigh();
        int g = 0;
        while (!bus.phi2 && g < 100) begin @(negedge fpgaClk); g++; end
        check("phi2_high_wait", 32'(g < 100), 1);
    endtask
    task automatic doAccess(input logic [ADDR_W-1:0] addr, input bit v, input int ackDelay,
                            input bit flushWithAck, output bit missed, output int slot0,
                            output int slot1, output int fills, output int lowCycles,
                            output int tagSeen);
        int g;
        int reqAge = 0;
        bit prevReq = 0;
        missed = 0; slot0 = -1; slot1 = -1; fills = 0; lowCycles = 0; tagSeen = -1;
        waitPhiHigh();
        bus.a = addr;
        bus.addrValid = v;
        g = 0;
        while (bus.phi2 && g < 100) begin @(negedge fpgaClk); g++; end
        g = 0;
        while (!bus.phi2 && g < 200) begin
            lowCycles++;
            bus.fillAck = 0;
            bus.flushAll = 0;
            if (bus.fillReq) begin
                if (!prevReq) begin
                    fills++;
                    reqAge = 0;
                    if (fills == 1) begin slot0 = int'(bus.fillSlot); tagSeen = int'(bus.fillTag); end
                    else slot1 = int'(bus.fillSlot);
                end
                reqAge++;
                if (reqAge == ackDelay + 1) begin
                    bus.fillAck = 1;
                    bus.flushAll = flushWithAck && fills == 1;
                end
            end
            missed |= bus.fillReq;
            prevReq = bus.fillReq;
            @(negedge fpgaClk);
            g++;
        end
        bus.fillAck = 0;
        bus.flushAll = 0;
        check("access_done", 32'(g < 200), 1);
    endtask
    task automatic pulseFlush();
        waitPhiHigh();
        bus.flushAll = 1;
        @(negedge fpgaClk);
        bus.flushAll = 0;
    endtask
    function automatic logic [ADDR_W-1:0] tagAddr(input int t);
        return ADDR_W'(t * (1 << PAGE_W) + (t * 3 + 7));
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
    initial begin
        bit missed;
        int s0, s1, fills, low, tagSeen, g;
        int rrSlots [5] = '{0, 1, 2, 3, 0};
        bus.a = '0; bus.addrValid = 0; bus.flushAll = 0; bus.fillAck = 0;
        repeat (3) @(negedge fpgaClk);
        checkOn = 1;
        check("rst_phi2", 32'(bus.phi2), 0);
        check("rst_fillReq", 32'(bus.fillReq), 0);
        check("rst_hit", 32'(bus.hit), 0);
        check("rst_extAddr", 32'(bus.extAddr), 0);
        check("rst_missCount", 32'(bus.missCount), 0);
        fpgaRstN = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge fpgaClk);
            check("phi2_pattern", 32'(bus.phi2), 32'((k % 10) >= 5));
            check("idle_no_fill", 32'(bus.fillReq), 0);
        end
        // Cold miss then warm hit.
        doAccess(24'h012345, 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("cold_missed", 32'(missed), 1);
        check("cold_fillTag", tagSeen, 32'h0048);
        check("cold_fillSlot", s0, 0);
        check("cold_phi2_low", low, 10);
        check("cold_hit", 32'(bus.hit), 1);
        check("cold_extAddr", 32'(bus.extAddr), 32'h345);
        check("cold_missCount", 32'(bus.missCount), 1);
        doAccess(24'h012345, 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("warm_missed", 32'(missed), 0);
        check("warm_phi2_low", low, 5);
        check("warm_hit", 32'(bus.hit), 1);
        check("warm_extAddr", 32'(bus.extAddr), 32'h345);
        doAccess(24'h0ABCDE, 0, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("novalid_missed", 32'(missed), 0);
        check("novalid_hit", 32'(bus.hit), 0);
        check("novalid_extAddr", 32'(bus.extAddr), 32'h345);
        // Round-robin victims from a flushed table.
        pulseFlush();
        for (int t = 1; t <= 5; t++) begin
            doAccess(tagAddr(t), 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
            check("rr_missed", 32'(missed), 1);
            check("rr_slot", s0, rrSlots[t-1]);
        end
        check("rr_missCount", 32'(bus.missCount), 6);
        doAccess(tagAddr(1), 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("rr_tag1_missed", 32'(missed), 1);
        check("rr_tag1_slot", s0, 1);
        doAccess(tagAddr(5), 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("rr_tag5_missed", 32'(missed), 0);
        check("rr_tag5_extAddr", 32'(bus.extAddr), 22);
        // Flush after two fills, then flush coincident with fillAck.
        pulseFlush();
        doAccess(tagAddr(8), 1, 2, 0, missed, s0, s1, fills, low, tagSeen);
        doAccess(tagAddr(9), 1, 4, 0, missed, s0, s1, fills, low, tagSeen);
        check("fl_pre_slot", s0, 1);
        pulseFlush();
        doAccess(tagAddr(8), 1, 1, 0, missed, s0, s1, fills, low, tagSeen);
        check("fl_refill_missed", 32'(missed), 1);
        check("fl_refill_slot", s0, 0);
        doAccess(tagAddr(9), 1, 3, 1, missed, s0, s1, fills, low, tagSeen);
        check("fl_ack_fills", fills, 2);
        check("fl_ack_slot0", s0, 1);
        check("fl_ack_slot1", s1, 0);
        check("fl_ack_hit", 32'(bus.hit), 1);
        check("fl_ack_extAddr", 32'(bus.extAddr), 34);
        check("fl_missCount", 32'(bus.missCount), 12);
        // Reset in the middle of a fill; a late fillAck must be ignored.
        waitPhiHigh();
        bus.a = tagAddr(32);
        bus.addrValid = 1;
        g = 0;
        while (!bus.fillReq && g < 100) begin @(negedge fpgaClk); g++; end
        check("mid_fill_seen", 32'(bus.fillReq), 1);
        fpgaRstN = 0;
        bus.fillAck = 1;
        bus.addrValid = 0;
        @(negedge fpgaClk);
        check("mid_rst_fillReq", 32'(bus.fillReq), 0);
        check("mid_rst_phi2", 32'(bus.phi2), 0);
        check("mid_rst_missCount", 32'(bus.missCount), 0);
        fpgaRstN = 1;
        bus.fillAck = 0;
        repeat (3) @(negedge fpgaClk);
        bus.fillAck = 1;
        @(negedge fpgaClk);
        bus.fillAck = 0;
        check("late_ack_fillReq", 32'(bus.fillReq), 0);
        doAccess(tagAddr(8), 1, 3, 0, missed, s0, s1, fills, low, tagSeen);
        check("post_rst_missed", 32'(missed), 1);
        check("post_rst_slot", s0, 0);
        check("post_rst_missCount", 32'(bus.missCount), 1);
        repeat (5) @(negedge fpgaClk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/cache_tag_mmu.md
Name: cache_tag_mmu

Overview:
- Parametrised page-tag cache controller and CPU clock generator.
- Derives phi2 from fpgaClk with a programmable phase counter.
- Once per CPU cycle, compares the page tag of the CPU address against ENTRIES tag slots and produces a cache-local external address on a hit.
- On a miss, stretches phi2 low, runs a fill handshake toward the backing-memory loader, installs the tag into a round-robin victim slot, then completes the cycle.

Parameters:
- ADDR_W, 24, CPU address width.
- PAGE_W, 10, page offset bits; TAG_W = ADDR_W-PAGE_W.
- ENTRIES, 4, tag slots; power of two, >=2; SLOT_W = log2(ENTRIES).
- PHI_PERIOD, 10, fpgaClk cycles per unstalled CPU cycle; >=4.
- PHI_HIGH, 5, counter value at which phi2 rises; 2..PHI_PERIOD-1.

Ports:
- fpgaClk  in  1  system clock
- fpgaRstN  in  1  reset; synchronous, active-low
- a  in  ADDR_W  CPU address, stable while phi2 low
- addrValid  in  1  current CPU cycle needs translation
- flushAll  in  1  invalidate all slots
- phi2  out  1  CPU clock
- hit  out  1  registered: last lookup hit
- extAddr  out  SLOT_W+PAGE_W  registered {slot, a[PAGE_W-1:0]}
- fillReq  out  1  fill request, level
- fillTag  out  TAG_W  tag being filled
- fillSlot  out  SLOT_W  victim slot being filled
- fillAck  in  1  fill complete (one-cycle pulse, sampled only while fillReq=1)
- missCount  out  16  saturating miss counter

Behaviour:
- Clocking: one clock, fpgaClk. Reset is synchronous and active-low on fpgaRstN.
- Reset values (on the fpgaClk edge with fpgaRstN=0):
  - cnt=0, state=RUN.
  - All valid bits=0, victim pointer=0.
  - fillReq=0, hit=0, extAddr=0, missCount=0.
  - phi2=0.
  - Reset mid-fill drops fillReq on the next edge. A fillAck arriving in the reset cycle is ignored.
- phi2 = (cnt >= PHI_HIGH). It is combinational from the registered cnt and therefore glitch-free.
- RUN state, cnt advances by 1 each edge and wraps PHI_PERIOD-1 -> 0, except at the lookup edge:
  - Lookup edge is cnt == PHI_HIGH-1 in RUN.
  - tag = a[ADDR_W-1:PAGE_W]. Per-slot match = valid[i] && tagReg[i]==tag.
  - addrValid=0: cnt advances, hit<=0, extAddr unchanged.
  - Match: cnt advances, hit<=1, extAddr<={lowest matching index, offset}.
  - No match: hit<=0, cnt held, state<=FILL, fillReq<=1, fillTag<=tag, fillSlot<=victim, missCount increments (saturating at 16'hFFFF).
- FILL state:
  - cnt held at PHI_HIGH-1, so phi2 stays low and the CPU is stalled.
  - fillReq, fillTag and fillSlot are held stable until fillAck.
  - On the edge with fillReq && fillAck: tagReg[fillSlot]<=fillTag, valid[fillSlot]<=1, victim<=victim+1 (wraps mod ENTRIES), fillReq<=0, state<=RUN.
  - The next edge repeats the lookup, which hits. A miss therefore costs fill wait + 2 fpgaClk cycles of added phi2-low time.
- Victim selection is strictly round-robin. Valid bits and hit history do not affect it.
- flushAll, any state, any cycle:
  - valid<=0 and victim<=0 on the next edge.
  - Coincident with a fill-completing fillAck, flush wins and the slot stays invalid. FILL still exits to RUN, the re-lookup misses and a new fill starts.
  - flushAll on a lookup edge: the lookup uses the pre-flush valid bits.
- Duplicate tags cannot arise through fills. If present, the lowest index wins.
- Tag storage is registers (no RAM inference required). Outputs change only on fpgaClk edges.

Test Plan:
- Reset/clock: hold fpgaRstN=0 3 cycles, release -> all outputs 0; phi2 low for cnt 0..4 and high for 5..9, repeating with period 10; addrValid=0 never raises fillReq.
- Cold miss: a=24'h012345, addrValid=1, fillAck 3 cycles after fillReq rises -> fillReq rises the edge after cnt=4; fillTag=14'h0048, fillSlot=0; phi2 low 10 cycles total that CPU cycle; then hit=1, extAddr={2'd0,10'h345}; missCount=1.
- Warm hit: repeat a=24'h012345 -> no fillReq, hit=1 at cnt 4->5 edge, phi2 period exactly 10.
- Round-robin: misses on tags 1,2,3,4,5 -> fillSlot 0,1,2,3,0; tag 1 then misses, tag 5 hits with extAddr slot 0; missCount=6.
- Flush: fill 2 slots, pulse flushAll -> next access to a filled tag misses with fillSlot=0; flushAll coincident with fillAck -> re-lookup misses again and fillReq re-asserts.
- Reset mid-fill: assert fpgaRstN=0 while fillReq=1 -> fillReq=0 next edge, valid cleared, cnt=0, later fillAck ignored.
